// File: rtl/multicycle_ctrl_unit.sv
// Multicycle MIPS control unit: decodes op/funct, sequences the instruction
// phases (fetch, decode, execute, memory, writeback) and drives every datapath
// enable and mux select. Includes the ALU decoder, the memory wait-state
// handshake, PC-enable generation and an illegal-instruction flag.
module multicycle_ctrl_unit #(
  parameter int ULA_W       = 3,
  parameter bit HAS_JAL     = 1'b1,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [ULA_W-1:0] ula_control,
  output logic             ula_src_a,
  output logic [1:0]       ula_src_b,
  output logic             imm_zext,
  output logic [1:0]       pc_src,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             illegal_op,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC     = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_IEXEC    = 4'd9,
    S_IWB      = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] w_ula;
  logic [2:0] w_alu_funct;
  logic [2:0] w_alu_imm;
  logic       w_funct_ok;
  logic       w_mem_done;

  // Opcode classification.
  logic w_is_lw, w_is_sw, w_is_rtype, w_is_beq, w_is_bne;
  logic w_is_addi, w_is_andi, w_is_ori, w_is_slti, w_is_j, w_is_jal;

  assign w_is_lw    = (op == 6'b100011);
  assign w_is_sw    = (op == 6'b101011);
  assign w_is_rtype = (op == 6'b000000);
  assign w_is_beq   = (op == 6'b000100);
  assign w_is_bne   = (op == 6'b000101);
  assign w_is_addi  = (op == 6'b001000);
  assign w_is_andi  = (op == 6'b001100);
  assign w_is_ori   = (op == 6'b001101);
  assign w_is_slti  = (op == 6'b001010);
  assign w_is_j     = (op == 6'b000010);
  assign w_is_jal   = HAS_JAL && (op == 6'b000011);

  // A memory access completes on mem_ready, or every cycle for single-cycle memory.
  assign w_mem_done = !MEM_WAIT_EN || mem_ready;

  // ALU operation for R-type instructions, plus legality of the funct field.
  always_comb begin
    w_alu_funct = ALU_ADD;
    w_funct_ok  = 1'b1;
    case (funct)
      6'b100000: w_alu_funct = ALU_ADD;
      6'b100010: w_alu_funct = ALU_SUB;
      6'b100100: w_alu_funct = ALU_AND;
      6'b100101: w_alu_funct = ALU_OR;
      6'b101010: w_alu_funct = ALU_SLT;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  // ALU operation for immediate-form instructions.
  always_comb begin
    w_alu_imm = ALU_ADD;
    if (w_is_andi)      w_alu_imm = ALU_AND;
    else if (w_is_ori)  w_alu_imm = ALU_OR;
    else if (w_is_slti) w_alu_imm = ALU_SLT;
  end

  // State register; reset returns to FETCH at once, abandoning any instruction.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next_state;
  end

  // Next-state and output decode; outputs stay at their idle values while in reset.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_next_state = S_FETCH;
    w_ula        = ALU_ADD;
    ula_src_a    = 1'b0;
    ula_src_b    = 2'b00;
    imm_zext     = 1'b0;
    pc_src       = 2'b00;
    pc_en        = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 2'b00;
    mem_to_reg   = 2'b00;
    illegal_op   = 1'b0;
    if (rst) begin
      case (r_state)
        S_FETCH: begin
          mem_read     = 1'b1;
          ula_src_b    = 2'b01;
          ir_write     = w_mem_done;
          pc_en        = w_mem_done;
          w_next_state = w_mem_done ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          ula_src_b = 2'b11;
          if (w_is_lw || w_is_sw)                               w_next_state = S_MEMADR;
          else if (w_is_rtype && w_funct_ok)                    w_next_state = S_EXEC;
          else if (w_is_beq || w_is_bne)                        w_next_state = S_BRANCH;
          else if (w_is_addi || w_is_andi || w_is_ori || w_is_slti) w_next_state = S_IEXEC;
          else if (w_is_j)                                      w_next_state = S_JUMP;
          else if (w_is_jal)                                    w_next_state = S_JAL;
          else                                                  illegal_op   = 1'b1;
        end
        S_MEMADR: begin
          ula_src_a    = 1'b1;
          ula_src_b    = 2'b10;
          w_next_state = w_is_sw ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          iord         = 1'b1;
          mem_read     = 1'b1;
          w_next_state = w_mem_done ? S_MEMWB : S_MEMREAD;
        end
        S_MEMWRITE: begin
          iord         = 1'b1;
          mem_write    = 1'b1;
          w_next_state = w_mem_done ? S_FETCH : S_MEMWRITE;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
        end
        S_EXEC: begin
          ula_src_a    = 1'b1;
          w_ula        = w_alu_funct;
          w_next_state = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
        end
        S_BRANCH: begin
          ula_src_a = 1'b1;
          w_ula     = ALU_SUB;
          pc_src    = 2'b01;
          pc_en     = w_is_bne ? !zero : zero;
        end
        S_IEXEC: begin
          ula_src_a    = 1'b1;
          ula_src_b    = 2'b10;
          w_ula        = w_alu_imm;
          imm_zext     = w_is_andi || w_is_ori;
          w_next_state = S_IWB;
        end
        S_IWB: begin
          reg_write = 1'b1;
        end
        S_JUMP: begin
          pc_src = 2'b10;
          pc_en  = 1'b1;
        end
        S_JAL: begin
          pc_src     = 2'b10;
          pc_en      = 1'b1;
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
        default: w_next_state = S_FETCH;
      endcase
    end
  end

  assign ula_control = ULA_W'(w_ula);
  assign state_o     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Self-checking bench for multicycle_ctrl_unit. Two instances: A with JAL and
// memory wait states enabled, B with both disabled. The idle instance is held
// in reset. Each instruction is expanded by a reference model into its expected
// phase trace, memory handshake and per-instruction totals of writes/enables.
module tb_multicycle_ctrl_unit;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  typedef enum int {C_LW, C_SW, C_R, C_BR, C_I, C_J, C_JAL, C_ILL} cls_t;

  typedef struct packed {
    logic [2:0] ula;
    logic       src_a;
    logic [1:0] src_b;
    logic       zext;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rw;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic       ill;
    logic [3:0] st;
  } outs_t;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [5:0] op, funct;
  logic       zero, rdy_a, rdy_b;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  logic [2:0] a_ula, b_ula;
  logic [1:0] a_src_b, b_src_b, a_pc_src, b_pc_src, a_rdst, b_rdst, a_m2r, b_m2r;
  logic       a_src_a, b_src_a, a_zext, b_zext, a_pc_en, b_pc_en, a_iord, b_iord;
  logic       a_mrd, b_mrd, a_mwr, b_mwr, a_irw, b_irw, a_rw, b_rw, a_ill, b_ill;
  logic [3:0] a_st, b_st;
  outs_t      oa, ob;

  multicycle_ctrl_unit #(.ULA_W(3), .HAS_JAL(1'b1), .MEM_WAIT_EN(1'b1)) u_dut_a (
    .clk(clk), .rst(rst_a), .op(op), .funct(funct), .zero(zero), .mem_ready(rdy_a),
    .ula_control(a_ula), .ula_src_a(a_src_a), .ula_src_b(a_src_b), .imm_zext(a_zext),
    .pc_src(a_pc_src), .pc_en(a_pc_en), .iord(a_iord), .mem_read(a_mrd), .mem_write(a_mwr),
    .ir_write(a_irw), .reg_write(a_rw), .reg_dst(a_rdst), .mem_to_reg(a_m2r),
    .illegal_op(a_ill), .state_o(a_st)
  );

  multicycle_ctrl_unit #(.ULA_W(3), .HAS_JAL(1'b0), .MEM_WAIT_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst_b), .op(op), .funct(funct), .zero(zero), .mem_ready(rdy_b),
    .ula_control(b_ula), .ula_src_a(b_src_a), .ula_src_b(b_src_b), .imm_zext(b_zext),
    .pc_src(b_pc_src), .pc_en(b_pc_en), .iord(b_iord), .mem_read(b_mrd), .mem_write(b_mwr),
    .ir_write(b_irw), .reg_write(b_rw), .reg_dst(b_rdst), .mem_to_reg(b_m2r),
    .illegal_op(b_ill), .state_o(b_st)
  );

  assign oa = '{a_ula, a_src_a, a_src_b, a_zext, a_pc_src, a_pc_en, a_iord, a_mrd, a_mwr,
                a_irw, a_rw, a_rdst, a_m2r, a_ill, a_st};
  assign ob = '{b_ula, b_src_a, b_src_b, b_zext, b_pc_src, b_pc_en, b_iord, b_mrd, b_mwr,
                b_irw, b_rw, b_rdst, b_m2r, b_ill, b_st};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction class from the architectural opcode table.
  function automatic cls_t classify(input logic [5:0] o, input logic [5:0] f, input bit has_jal);
    case (o)
      OP_LW:                             return C_LW;
      OP_SW:                             return C_SW;
      OP_R:    return (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) ? C_R : C_ILL;
      OP_BEQ, OP_BNE:                    return C_BR;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return C_I;
      OP_J:                              return C_J;
      OP_JAL:                            return has_jal ? C_JAL : C_ILL;
      default:                           return C_ILL;
    endcase
  endfunction

  // ALU operation the instruction semantics require during execute.
  function automatic logic [2:0] alu_for(input logic [5:0] o, input logic [5:0] f);
    if (o == OP_R) begin
      case (f)
        6'b100010: return 3'b110;
        6'b100100: return 3'b000;
        6'b100101: return 3'b001;
        6'b101010: return 3'b111;
        default:   return 3'b010;
      endcase
    end
    case (o)
      OP_ANDI: return 3'b000;
      OP_ORI:  return 3'b001;
      OP_SLTI: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Append one memory access phase: wait cycles with ready low, then the completing cycle.
  function automatic void push_mem(ref step_t q[$], input logic [3:0] st, input int waits,
                                   input bit mem_wait);
    if (mem_wait) begin
      for (int i = 0; i < waits; i++) q.push_back('{st, 1'b0});
      q.push_back('{st, 1'b1});
    end else begin
      q.push_back('{st, 1'b0});
    end
  endfunction

  // Run one instruction from FETCH on instance A or B and check it against the model.
  task automatic run_instr(input bit use_b, input logic [5:0] opv, input logic [5:0] fv,
                           input logic zv, input int fw, input int mw);
    bit     has_jal  = !use_b;
    bit     mem_wait = !use_b;
    cls_t   cls      = classify(opv, fv, has_jal);
    step_t  q[$];
    outs_t  o;
    int     n_rw = 0, n_pc = 0, n_mrd = 0, n_mwr = 0, n_irw = 0, n_ill = 0;
    int     e_mrd, e_mwr, e_pc, e_rw;
    logic [1:0] e_rdst, e_m2r;
    bit     taken;

    push_mem(q, 4'd0, fw, mem_wait);
    q.push_back('{4'd1, 1'($urandom)});
    case (cls)
      C_LW:  begin q.push_back('{4'd2, 1'($urandom)}); push_mem(q, 4'd3, mw, mem_wait);
                   q.push_back('{4'd4, 1'($urandom)}); end
      C_SW:  begin q.push_back('{4'd2, 1'($urandom)}); push_mem(q, 4'd5, mw, mem_wait); end
      C_R:   begin q.push_back('{4'd6, 1'($urandom)}); q.push_back('{4'd7, 1'($urandom)}); end
      C_BR:  q.push_back('{4'd8, 1'($urandom)});
      C_I:   begin q.push_back('{4'd9, 1'($urandom)}); q.push_back('{4'd10, 1'($urandom)}); end
      C_J:   q.push_back('{4'd11, 1'($urandom)});
      C_JAL: q.push_back('{4'd12, 1'($urandom)});
      default: ;
    endcase

    taken  = (cls == C_BR) && ((opv == OP_BEQ) ? zv : !zv);
    e_rw   = (cls inside {C_LW, C_R, C_I, C_JAL}) ? 1 : 0;
    e_mrd  = (mem_wait ? fw + 1 : 1) + ((cls == C_LW) ? (mem_wait ? mw + 1 : 1) : 0);
    e_mwr  = (cls == C_SW) ? (mem_wait ? mw + 1 : 1) : 0;
    e_pc   = 1 + ((cls inside {C_J, C_JAL}) ? 1 : 0) + (taken ? 1 : 0);
    e_rdst = (cls == C_R) ? 2'b01 : (cls == C_JAL) ? 2'b10 : 2'b00;
    e_m2r  = (cls == C_LW) ? 2'b01 : (cls == C_JAL) ? 2'b10 : 2'b00;

    op = opv; funct = fv; zero = zv;
    foreach (q[k]) begin
      if (use_b) rdy_b = q[k].rdy; else rdy_a = q[k].rdy;
      @(negedge clk);
      o = use_b ? ob : oa;
      check("state", 32'(o.st), 32'(q[k].st));
      if (o.rw)  begin n_rw++; check("reg_dst", 32'(o.rdst), 32'(e_rdst));
                              check("mem_to_reg", 32'(o.m2r), 32'(e_m2r)); end
      if (o.pc_en) begin n_pc++;
        check("pc_src", 32'(o.pc_src), (q[k].st == 4'd0) ? 32'd0 : (cls == C_BR) ? 32'd1 : 32'd2);
      end
      if (o.mrd || o.mwr) check("iord", 32'(o.iord), 32'(q[k].st != 4'd0));
      if (q[k].st == 4'd6 || q[k].st == 4'd9) begin
        check("alu_exec", 32'(o.ula), 32'(alu_for(opv, fv)));
        check("imm_zext", 32'(o.zext), 32'(opv == OP_ANDI || opv == OP_ORI));
      end
      if (q[k].st == 4'd8) check("alu_branch", 32'(o.ula), 32'h6);
      n_mrd += int'(o.mrd); n_mwr += int'(o.mwr); n_irw += int'(o.irw); n_ill += int'(o.ill);
      @(posedge clk); #1;
    end
    check("n_reg_write", n_rw, e_rw);
    check("n_pc_en", n_pc, e_pc);
    check("n_mem_read", n_mrd, e_mrd);
    check("n_mem_write", n_mwr, e_mwr);
    check("n_ir_write", n_irw, 1);
    check("n_illegal", n_ill, (cls == C_ILL) ? 1 : 0);
  endtask

  task automatic run_random(input bit use_b, input int n);
    logic [5:0] ops [12] = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI,
                              OP_SLTI, OP_J, OP_JAL, 6'b111111};
    logic [5:0] fns [5]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] o, f;
    for (int i = 0; i < n; i++) begin
      o = ops[$urandom_range(11)];
      if (o == 6'b111111) o = 6'($urandom);
      f = ($urandom_range(4) == 0) ? 6'($urandom) : fns[$urandom_range(4)];
      run_instr(use_b, o, f, 1'($urandom), $urandom_range(3), $urandom_range(3));
    end
  endtask

  outs_t rst_exp;

  initial begin
    rst_exp = '0;
    rst_exp.ula = 3'b010;
    rst_a = 1'b0; rst_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    op = OP_R; funct = 6'b100000; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_idle_a", 32'(oa), 32'(rst_exp));
    rst_a = 1'b1;

    // Reset asserted while LW waits in MEMREAD.
    op = OP_LW; rdy_a = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rdy_a = 1'b0;
    @(negedge clk);
    check("pre_rst_state", 32'(oa.st), 32'd3);
    #1 rst_a = 1'b0;
    #1 check("async_rst", 32'(oa), 32'(rst_exp));
    @(posedge clk); #1;
    check("held_rst", 32'(oa), 32'(rst_exp));
    rst_a = 1'b1;
    #1 check("rst_release_state", 32'(oa.st), 32'd0);
    check("rst_release_mrd", 32'(oa.mrd), 32'd1);

    // LW with two wait cycles in FETCH and in MEMREAD.
    run_instr(1'b0, OP_LW, 6'd0, 1'b0, 2, 2);
    check("lw_back_to_fetch", 32'(oa.st), 32'd0);
    // Branch taken/not-taken combinations.
    run_instr(1'b0, OP_BEQ, 6'd0, 1'b1, 0, 0);
    run_instr(1'b0, OP_BNE, 6'd0, 1'b1, 0, 0);
    run_instr(1'b0, OP_BNE, 6'd0, 1'b0, 1, 0);
    // R-type slt, illegal funct, ANDI, JAL, SW with waits.
    run_instr(1'b0, OP_R, 6'b101010, 1'b0, 0, 0);
    run_instr(1'b0, OP_R, 6'b000111, 1'b0, 0, 0);
    run_instr(1'b0, OP_ANDI, 6'd0, 1'b0, 0, 0);
    run_instr(1'b0, OP_JAL, 6'd0, 1'b0, 0, 0);
    run_instr(1'b0, OP_SW, 6'd0, 1'b0, 1, 3);
    run_random(1'b0, 80);

    // Instance B: no JAL, single-cycle memory.
    rst_a = 1'b0;
    rst_b = 1'b1;
    run_instr(1'b1, OP_JAL, 6'd0, 1'b0, 0, 0);
    run_instr(1'b1, OP_LW, 6'd0, 1'b0, 2, 2);
    run_instr(1'b1, OP_SW, 6'd0, 1'b0, 2, 2);
    run_random(1'b1, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
